// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM controller: FSM encoding, SRAM bus widths
// and the default access timing.
package sram_ctrl_pkg;

  // Access sequencer states: IDLE waits for a request, LO and HI drive the
  // low and high 16-bit halves, DONE is the single ready cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int SRAM_AW        = 18;
  localparam int SRAM_DW        = 16;
  localparam int ACC_CYCLES_DEF = 3;

  // Wide enough for the largest legal ACC_CYCLES (15).
  localparam int CNT_W = 4;

endpackage

// File: rtl/sram_ctrl_if.sv
// Pipeline-side bus of the SRAM controller.
//
// Handshake: a request (wr_en or rd_en) is taken in the first cycle the
// controller is idle and sees it; ready is low from that cycle until the
// access completes, and is high for exactly one completion cycle (DONE).
// Requests seen while ready is low belong to the pipeline's frozen stage
// and are ignored; the pipeline keeps its request stable while ready is low.
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] st_value;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output wr_en, rd_en, address, st_value,
    input  read_data, ready
  );

  modport slave (
    input  wr_en, rd_en, address, st_value,
    output read_data, ready
  );

endinterface

// File: rtl/sram_phase_timer.sv
// Phase cycle counter: counts 0..ACC_CYCLES-1 within one access phase and
// flags the last cycle. It saturates there instead of wrapping.
module sram_phase_timer
  import sram_ctrl_pkg::*;
#(
  parameter int ACC_CYCLES = ACC_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  assign last = (cnt == CNT_W'(ACC_CYCLES - 1));

  // Clear on phase entry, otherwise advance until the last phase cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && !last) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// 32-bit pipeline load/store port onto a 16-bit asynchronous SRAM. Each
// access is split into a low and a high half-word phase of ACC_CYCLES
// cycles each, followed by one DONE cycle in which the pipeline may advance.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ACC_CYCLES = ACC_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sram_ctrl_if.slave         pipe,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n,
  output state_t             dbg_state
);

  state_t      state;
  state_t      next_state;
  logic        accept;
  logic        in_phase;
  logic        phase_clear;
  logic        last;
  logic        op_wr;
  logic [16:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] read_data_q;

  // Only word address bits [18:2] reach the SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{pipe.address[31:19], pipe.address[1:0]};

  assign dbg_state      = state;
  assign pipe.read_data = read_data_q;

  assign in_phase    = (state == LO) || (state == HI);
  // Any state change starts a fresh phase count; outside a phase it stays 0.
  assign phase_clear = (state != next_state) || !in_phase;

  sram_phase_timer #(
    .ACC_CYCLES(ACC_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (phase_clear),
    .enable(in_phase),
    .last  (last)
  );

  // State register; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a request is only taken in IDLE, never in DONE.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (pipe.wr_en || pipe.rd_en) begin
          next_state = LO;
          accept     = 1'b1;
        end
      end
      LO:      if (last) next_state = HI;
      HI:      if (last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Capture the request when it is accepted; later input changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else if (accept) begin
      op_wr  <= pipe.wr_en;
      addr_q <= pipe.address[18:2];
      data_q <= pipe.st_value;
    end
  end

  // Sample SRAM read data on the last cycle of each read phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_q <= '0;
    end else if (!op_wr && last) begin
      if (state == LO) read_data_q[15:0]  <= sram_dq_in;
      if (state == HI) read_data_q[31:16] <= sram_dq_in;
    end
  end

  // SRAM strobes and pipeline ready, decoded from state, counter and latches.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_ce_n   = 1'b1;
    sram_ub_n   = 1'b1;
    sram_lb_n   = 1'b1;
    pipe.ready  = 1'b0;
    case (state)
      IDLE: pipe.ready = !(pipe.wr_en || pipe.rd_en);
      LO, HI: begin
        sram_ce_n = 1'b0;
        sram_ub_n = 1'b0;
        sram_lb_n = 1'b0;
        sram_addr = {addr_q, (state == HI)};
        if (op_wr) begin
          sram_dq_oe  = 1'b1;
          sram_dq_out = (state == HI) ? data_q[31:16] : data_q[15:0];
          // Release we_n one cycle early so data is held past the strobe.
          sram_we_n   = last;
        end else begin
          sram_oe_n = 1'b0;
        end
      end
      DONE:    pipe.ready = 1'b1;
      default: pipe.ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: one instance at ACC_CYCLES=3 with a small
// SRAM model, one at ACC_CYCLES=2 for back-to-back read timing.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int A_CYC = 3;
  localparam int B_CYC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_ctrl_if pa ();
  sram_ctrl_if pb ();

  logic [17:0] addr_a, addr_b;
  logic [15:0] dq_out_a, dq_out_b, dq_in_a, dq_in_b;
  logic        dq_oe_a, dq_oe_b;
  logic        we_n_a, oe_n_a, ce_n_a, ub_n_a, lb_n_a;
  logic        we_n_b, oe_n_b, ce_n_b, ub_n_b, lb_n_b;
  state_t      state_a, state_b;

  sram_ctrl #(.ACC_CYCLES(A_CYC)) dut_a (
    .clk(clk), .rst(rst), .pipe(pa),
    .sram_addr(addr_a), .sram_dq_out(dq_out_a), .sram_dq_oe(dq_oe_a),
    .sram_dq_in(dq_in_a), .sram_we_n(we_n_a), .sram_oe_n(oe_n_a),
    .sram_ce_n(ce_n_a), .sram_ub_n(ub_n_a), .sram_lb_n(lb_n_a),
    .dbg_state(state_a)
  );

  sram_ctrl #(.ACC_CYCLES(B_CYC)) dut_b (
    .clk(clk), .rst(rst), .pipe(pb),
    .sram_addr(addr_b), .sram_dq_out(dq_out_b), .sram_dq_oe(dq_oe_b),
    .sram_dq_in(dq_in_b), .sram_we_n(we_n_b), .sram_oe_n(oe_n_b),
    .sram_ce_n(ce_n_b), .sram_ub_n(ub_n_b), .sram_lb_n(lb_n_b),
    .dbg_state(state_b)
  );

  // SRAM model for instance A: written while ce_n and we_n are low.
  logic [15:0] mem [0:255];
  assign dq_in_a = mem[addr_a[7:0]];
  always @(posedge clk) begin
    if (!ce_n_a && !we_n_a && dq_oe_a) mem[addr_a[7:0]] <= dq_out_a;
  end
  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
  end

  // Instance B reads a pattern derived from the half-word address.
  assign dq_in_b = addr_b[15:0] ^ 16'h5A00;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // One access on instance A; checks every phase cycle, returns cycles to ready.
  task automatic access_a(input logic wr, input logic rd, input logic [31:0] addr,
                          input logic [31:0] val, input bit mid_change, output int lat);
    int   cyc;
    logic half;
    logic [17:0] exp_addr;
    @(negedge clk);
    pa.wr_en = wr; pa.rd_en = rd; pa.address = addr; pa.st_value = val;
    #1;
    check("req_ready_low", {31'b0, pa.ready}, 32'd0);
    check("req_state_idle", {30'b0, state_a}, {30'b0, IDLE});
    @(posedge clk);
    #1;
    pa.wr_en = 1'b0; pa.rd_en = 1'b0;
    if (mid_change) begin
      pa.address  = addr ^ 32'h0000_0FF0;
      pa.st_value = ~val;
    end
    lat = 0;
    cyc = 1;
    while (lat == 0 && cyc < 40) begin
      @(negedge clk);
      if (pa.ready) begin
        lat = cyc;
        check("done_ce_off", {29'b0, ce_n_a, ub_n_a, lb_n_a}, 32'd7);
        check("done_addr_zero", {14'b0, addr_a}, 32'd0);
      end else begin
        half     = (cyc > A_CYC);
        exp_addr = {addr[18:2], half};
        check("phase_ce_on", {29'b0, ce_n_a, ub_n_a, lb_n_a}, 32'd0);
        check("phase_addr", {14'b0, addr_a}, {14'b0, exp_addr});
        if (wr) begin
          check("wr_dq_out", {16'b0, dq_out_a}, {16'b0, half ? val[31:16] : val[15:0]});
          check("wr_dq_oe", {31'b0, dq_oe_a}, 32'd1);
          check("wr_oe_n", {31'b0, oe_n_a}, 32'd1);
          check("wr_we_n", {31'b0, we_n_a},
                (cyc == A_CYC || cyc == 2 * A_CYC) ? 32'd1 : 32'd0);
        end else begin
          check("rd_oe_n", {31'b0, oe_n_a}, 32'd0);
          check("rd_dq_oe", {31'b0, dq_oe_a}, 32'd0);
          check("rd_we_n", {31'b0, we_n_a}, 32'd1);
        end
      end
      cyc++;
    end
  endtask

  // ---------------- stimulus ----------------
  int lat;
  int ce_low;
  int rise_seen;
  int rise_t;

  initial begin
    rst = 1'b1;
    pa.wr_en = 1'b0; pa.rd_en = 1'b0; pa.address = '0; pa.st_value = '0;
    pb.wr_en = 1'b0; pb.rd_en = 1'b0; pb.address = '0; pb.st_value = '0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_state", {30'b0, state_a}, {30'b0, IDLE});
    check("rst_ready", {31'b0, pa.ready}, 32'd1);
    check("rst_strobes", {27'b0, we_n_a, oe_n_a, ce_n_a, ub_n_a, lb_n_a}, 32'h1F);
    check("rst_dq_oe", {31'b0, dq_oe_a}, 32'd0);
    check("rst_addr", {14'b0, addr_a}, 32'd0);
    check("rst_dq_out", {16'b0, dq_out_a}, 32'd0);
    check("rst_read_data", pa.read_data, 32'd0);
    rst = 1'b0;

    // Write DEADBEEF to 0x10.
    access_a(1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, lat);
    check("wr_latency", lat, 2 * A_CYC + 1);
    check("wr_keeps_read_data", pa.read_data, 32'd0);

    // Read it back through an address with ignored upper/lower bits set.
    access_a(1'b0, 1'b1, 32'hFFF8_0013, 32'h0, 1'b0, lat);
    check("rd_latency", lat, 2 * A_CYC + 1);
    check("rd_data_deadbeef", pa.read_data, 32'hDEAD_BEEF);

    // Both requests: write wins, read_data untouched.
    access_a(1'b1, 1'b1, 32'h0000_0004, 32'h1234_5678, 1'b0, lat);
    check("both_latency", lat, 2 * A_CYC + 1);
    check("both_read_data_kept", pa.read_data, 32'hDEAD_BEEF);
    access_a(1'b0, 1'b1, 32'h0000_0004, 32'h0, 1'b0, lat);
    check("both_rd_back", pa.read_data, 32'h1234_5678);

    // Inputs changed mid-access are ignored.
    access_a(1'b1, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, 1'b1, lat);
    check("mid_latency", lat, 2 * A_CYC + 1);
    access_a(1'b0, 1'b1, 32'h0000_0020, 32'h0, 1'b1, lat);
    check("mid_rd_back", pa.read_data, 32'hCAFE_F00D);

    // Reset during HI of a write.
    @(negedge clk);
    pa.wr_en = 1'b1; pa.address = 32'h0000_0030; pa.st_value = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    pa.wr_en = 1'b0;
    repeat (A_CYC) @(posedge clk);
    #1;
    check("pre_rst_state_hi", {30'b0, state_a}, {30'b0, HI});
    #2;
    rst = 1'b1;
    #1;
    check("abort_strobes", {27'b0, we_n_a, oe_n_a, ce_n_a, ub_n_a, lb_n_a}, 32'h1F);
    check("abort_dq_oe", {31'b0, dq_oe_a}, 32'd0);
    check("abort_addr", {14'b0, addr_a}, 32'd0);
    check("abort_state", {30'b0, state_a}, {30'b0, IDLE});
    check("abort_read_data", pa.read_data, 32'd0);
    check("abort_ready", {31'b0, pa.ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    ce_low = 0;
    repeat (6) begin
      @(negedge clk);
      if (!ce_n_a || !we_n_a) ce_low++;
    end
    check("post_rst_quiet", ce_low, 0);

    // Back-to-back reads on instance B: ready rises at 5, 11, 17, 23.
    for (int k = 0; k < 4; k++) exp_q.push_back(32'(2 * B_CYC + 1 + k * (2 * B_CYC + 2)));
    @(negedge clk);
    pb.rd_en = 1'b1; pb.address = 32'h0000_0008;
    rise_seen = 0;
    for (int t = 0; t < 26; t++) begin
      #1;
      if (pb.ready) begin
        rise_t = t;
        if (rise_seen == 0) check("b2b_rd_data", pb.read_data, 32'h5A05_5A04);
        rise_seen++;
        if (exp_q.size() > 0) check("b2b_ready_time", rise_t, exp_q.pop_front());
        else check("b2b_extra_ready", rise_t, 32'hFFFF_FFFF);
      end
      @(negedge clk);
    end
    pb.rd_en = 1'b0;
    check("b2b_ready_count", rise_seen, 4);
    while (exp_q.size() > 0) check("b2b_missing_ready", 32'hFFFF_FFFF, exp_q.pop_front());

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case anything stalls.
  initial begin
    #200000;
    $display("FAIL timeout got=stalled exp=finished");
    $fatal(1, "timeout");
  end

endmodule
